// File: rtl/memory_writer_pkg.sv
// Shared defaults and helpers for memory_writer and its FIFO.
// No ports; provides default widths/depth and the packed-entry width helper.
package memory_writer_pkg;

    localparam int unsigned MW_ADDR_W_DEF = 32;
    localparam int unsigned MW_DATA_W_DEF = 32;
    localparam int unsigned MW_DEPTH_DEF  = 4;

    // Width of one buffered request: {wstrb, addr, data}.
    function automatic int unsigned mw_entry_w(input int unsigned aw, input int unsigned dw);
        return aw + dw + dw / 8;
    endfunction

endpackage

// File: rtl/global_defines.vh
// Shared width macros for the memory reader/writer family.
//   STRB_W(DW)  : byte-enable width for a DW-bit data bus
//   COUNT_W(D)  : width of an occupancy counter able to hold 0..D
`ifndef GLOBAL_DEFINES_VH
`define GLOBAL_DEFINES_VH

`define STRB_W(DW) ((DW) / 8)
`define COUNT_W(D) ($clog2(D) + 1)

`endif

// File: rtl/memory_writer_fifo.sv
// Generic synchronous in-order FIFO with asynchronous active-high reset.
// Ports:
//   clk, rst   : clock, async active-high reset (clears pointers, count, storage)
//   push, din  : write din at the write pointer when push is high
//   pop        : advance the read pointer when high
//   dout       : head entry, read straight from storage
//   count      : entries currently held (0..DEPTH)
// The caller guarantees no push when full without a pop, and no pop when empty.
`include "global_defines.vh"

module memory_writer_fifo
    import memory_writer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = MW_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [`COUNT_W(DEPTH)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = `COUNT_W(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Pointers wrap naturally because DEPTH is a power of two; full/empty
    // are tracked by the counter, never by comparing pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/memory_writer.sv
// Buffered write port: accepts {addr, data, wstrb} requests on a valid/ready
// slave interface and drains them in order, one per cycle, to a single-port
// memory write interface that may stall with mem_ready.
// Ports:
//   clk, rst                         : clock, async active-high reset
//   s_valid/s_ready                  : request handshake
//   s_addr, s_data, s_wstrb          : request payload (zero strobe = discarded)
//   mem_enable/mem_ready             : memory write handshake
//   mem_addr, mem_data, mem_wstrb    : head entry, registered (no s_* -> mem_* path)
//   count                            : entries buffered
//   idle                             : high when nothing is buffered
`include "global_defines.vh"

module memory_writer
    import memory_writer_pkg::*;
#(
    parameter int unsigned ADDR_W = MW_ADDR_W_DEF,
    parameter int unsigned DATA_W = MW_DATA_W_DEF,
    parameter int unsigned DEPTH  = MW_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [ADDR_W-1:0]           s_addr,
    input  logic [DATA_W-1:0]           s_data,
    input  logic [`STRB_W(DATA_W)-1:0]  s_wstrb,
    output logic                        mem_enable,
    output logic [`STRB_W(DATA_W)-1:0]  mem_wstrb,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_data,
    input  logic                        mem_ready,
    output logic [`COUNT_W(DEPTH)-1:0]  count,
    output logic                        idle
);

    localparam int unsigned ENTRY_W = mw_entry_w(ADDR_W, DATA_W);
    localparam int unsigned CNT_W   = `COUNT_W(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic               push;
    logic               pop;
    logic               full;
    logic [ENTRY_W-1:0] din;
    logic [ENTRY_W-1:0] dout;

    assign full       = (count == FULL_CNT);
    assign idle       = (count == '0);
    assign mem_enable = !idle;

    // When full, the head necessarily drains this cycle if mem_ready is high,
    // so a new request can take its slot in the same cycle.
    assign s_ready = !full || mem_ready;

    // Zero-strobe requests complete the handshake but are never stored.
    assign push = s_valid && s_ready && (s_wstrb != '0);
    assign pop  = mem_enable && mem_ready;

    assign din = {s_wstrb, s_addr, s_data};
    assign {mem_wstrb, mem_addr, mem_data} = dout;

    memory_writer_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .count (count)
    );

endmodule

// File: tb/tb_memory_writer.sv
module tb_memory_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_addr;
    logic [31:0] s_data;
    logic [3:0]  s_wstrb;
    logic        mem_enable;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [2:0]  count;
    logic        idle;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] mon_addr [$];
    logic [31:0] mon_data [$];
    logic [3:0]  mon_strb [$];
    int          mon_cyc  [$];

    memory_writer #(
        .ADDR_W (32),
        .DATA_W (32),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_addr     (s_addr),
        .s_data     (s_data),
        .s_wstrb    (s_wstrb),
        .mem_enable (mem_enable),
        .mem_wstrb  (mem_wstrb),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .count      (count),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change just after posedge, so at negedge they are stable for the
    // coming edge: record every memory write that edge will perform.
    always @(negedge clk) begin
        if (!rst && mem_enable && mem_ready) begin
            mon_addr.push_back(mem_addr);
            mon_data.push_back(mem_data);
            mon_strb.push_back(mem_wstrb);
            mon_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        s_valid = v;
        s_addr  = a;
        s_data  = d;
        s_wstrb = s;
        #1;
    endtask

    task automatic mon_clear();
        mon_addr.delete();
        mon_data.delete();
        mon_strb.delete();
        mon_cyc.delete();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && !idle; i++) tick();
        chk("drain_idle", 64'(idle), 64'(1));
    endtask

    function automatic logic [31:0] dpat(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        s_valid   = 1'b0;
        s_addr    = '0;
        s_data    = '0;
        s_wstrb   = '0;
        #1;
        chk("rst_count",      64'(count),      64'(0));
        chk("rst_idle",       64'(idle),       64'(1));
        chk("rst_mem_enable", 64'(mem_enable), 64'(0));
        chk("rst_s_ready",    64'(s_ready),    64'(1));
        chk("rst_mem_addr",   64'(mem_addr),   64'(0));
        chk("rst_mem_data",   64'(mem_data),   64'(0));
        chk("rst_mem_wstrb",  64'(mem_wstrb),  64'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single write with mem_ready high.
        mon_clear();
        mem_ready = 1'b1;
        drive(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        chk("single_s_ready", 64'(s_ready), 64'(1));
        tick();
        drive(1'b0, '0, '0, '0);
        chk("single_mem_enable", 64'(mem_enable), 64'(1));
        chk("single_mem_addr",   64'(mem_addr),   64'(32'h10));
        chk("single_mem_data",   64'(mem_data),   64'(32'hDEADBEEF));
        chk("single_mem_wstrb",  64'(mem_wstrb),  64'(4'hF));
        chk("single_count",      64'(count),      64'(1));
        tick();
        chk("single_idle_after",  64'(idle),       64'(1));
        chk("single_count_after", 64'(count),      64'(0));
        chk("single_enable_after",64'(mem_enable), 64'(0));
        chk("single_mon_n",       64'(mon_addr.size()), 64'(1));

        // Back-pressure: only DEPTH requests accepted while memory stalls.
        mon_clear();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i), dpat(32'(i)), 4'hF);
            chk("bp_accept", 64'(s_ready), 64'(1));
            tick();
        end
        drive(1'b1, 32'd4, dpat(32'd4), 4'hF);
        chk("bp_full_s_ready", 64'(s_ready), 64'(0));
        chk("bp_full_count",   64'(count),   64'(4));
        tick();
        chk("bp_hold_s_ready", 64'(s_ready),  64'(0));
        chk("bp_hold_count",   64'(count),    64'(4));
        chk("bp_hold_head",    64'(mem_addr), 64'(0));
        mem_ready = 1'b1;
        #1;
        chk("bp_release_s_ready", 64'(s_ready), 64'(1));
        tick();
        drive(1'b1, 32'd5, dpat(32'd5), 4'hF);
        chk("bp_last_s_ready", 64'(s_ready), 64'(1));
        tick();
        drive(1'b0, '0, '0, '0);
        drain();
        chk("bp_mon_n", 64'(mon_addr.size()), 64'(6));
        for (int i = 0; i < mon_addr.size() && i < 6; i++) begin
            chk("bp_order_addr", 64'(mon_addr[i]), 64'(i));
            chk("bp_order_data", 64'(mon_data[i]), 64'(dpat(32'(i))));
            if (i > 0) chk("bp_back_to_back", 64'(mon_cyc[i] - mon_cyc[i-1]), 64'(1));
        end

        // Full FIFO with simultaneous drain keeps accepting.
        mon_clear();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(i), dpat(32'h100 + 32'(i)), 4'hF);
            tick();
        end
        chk("fd_full_count", 64'(count), 64'(4));
        mem_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'h200 + 32'(k), dpat(32'h200 + 32'(k)), 4'hF);
            chk("fd_s_ready", 64'(s_ready), 64'(1));
            chk("fd_count",   64'(count),   64'(4));
            tick();
        end
        drive(1'b0, '0, '0, '0);
        drain();
        chk("fd_mon_n", 64'(mon_addr.size()), 64'(12));
        for (int i = 0; i < mon_addr.size() && i < 12; i++) begin
            logic [31:0] ea;
            ea = (i < 4) ? 32'h100 + 32'(i) : 32'h200 + 32'(i - 4);
            chk("fd_order_addr", 64'(mon_addr[i]), 64'(ea));
            chk("fd_order_data", 64'(mon_data[i]), 64'(dpat(ea)));
        end

        // Zero-strobe request is handshaken but dropped.
        mon_clear();
        mem_ready = 1'b1;
        drive(1'b1, 32'h20, 32'h1111_1111, 4'h0);
        chk("zs_zero_s_ready", 64'(s_ready), 64'(1));
        tick();
        drive(1'b1, 32'h24, 32'h2222_2222, 4'h3);
        chk("zs_zero_not_pushed", 64'(count),   64'(0));
        chk("zs_next_s_ready",    64'(s_ready), 64'(1));
        tick();
        drive(1'b0, '0, '0, '0);
        chk("zs_head_addr",  64'(mem_addr),  64'(32'h24));
        chk("zs_head_wstrb", 64'(mem_wstrb), 64'(4'h3));
        drain();
        chk("zs_mon_n", 64'(mon_addr.size()), 64'(1));
        if (mon_addr.size() > 0) begin
            chk("zs_mon_addr", 64'(mon_addr[0]), 64'(32'h24));
            chk("zs_mon_strb", 64'(mon_strb[0]), 64'(4'h3));
        end

        // Stalled head holds stable.
        mon_clear();
        mem_ready = 1'b0;
        drive(1'b1, 32'h40, 32'h1234_5678, 4'h5);
        tick();
        drive(1'b0, '0, '0, '0);
        for (int k = 0; k < 5; k++) begin
            chk("stall_enable", 64'(mem_enable), 64'(1));
            chk("stall_addr",   64'(mem_addr),   64'(32'h40));
            chk("stall_data",   64'(mem_data),   64'(32'h1234_5678));
            chk("stall_wstrb",  64'(mem_wstrb),  64'(4'h5));
            tick();
        end
        mem_ready = 1'b1;
        drain();
        chk("stall_mon_n", 64'(mon_addr.size()), 64'(1));

        // Reset with buffered entries drops them all.
        mon_clear();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h60 + 32'(i), dpat(32'h60 + 32'(i)), 4'hF);
            tick();
        end
        drive(1'b0, '0, '0, '0);
        chk("rm_count_before", 64'(count), 64'(3));
        rst = 1'b1;
        #1;
        chk("rm_enable_async", 64'(mem_enable), 64'(0));
        chk("rm_count_async",  64'(count),      64'(0));
        tick();
        rst       = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rm_count_after",   64'(count),      64'(0));
        chk("rm_idle_after",    64'(idle),       64'(1));
        chk("rm_s_ready_after", 64'(s_ready),    64'(1));
        chk("rm_enable_after",  64'(mem_enable), 64'(0));
        for (int k = 0; k < 4; k++) tick();
        chk("rm_no_write", 64'(mon_addr.size()), 64'(0));
        drive(1'b1, 32'h80, 32'hCAFE_F00D, 4'hC);
        tick();
        drive(1'b0, '0, '0, '0);
        drain();
        chk("rm_new_n", 64'(mon_addr.size()), 64'(1));
        if (mon_addr.size() > 0) begin
            chk("rm_new_addr", 64'(mon_addr[0]), 64'(32'h80));
            chk("rm_new_data", 64'(mon_data[0]), 64'(32'hCAFE_F00D));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
